axi_lite_dram_slave: RTL and testbench
======================================

# axi_lite_dram_slave

AXI4-Lite slave that sits directly downstream of the invalid/outvalid-to-AXI4-Lite bridge and serves its single-outstanding read and write transactions from a 256 × 32-bit word store. Every transaction must complete with a programmable response latency. The block replaces the behavioural DRAM model in simulation and is the formal target for bridge-to-memory handshake properties.

## Interface
Parameters:
- ADDR_W, 17, AXI address width.
- DATA_W, 32, data width.
- DEPTH, 256, words in store; index = ADDR[9:2].
- BASE_HI, 7'b1000000, required value of ADDR[16:10].
- RD_LAT, 2, cycles from AR handshake to R_VALID rise (1..15).
- WR_LAT, 1, cycles from W handshake to B_VALID rise (1..15).

Ports (the clock is `clk`; the reset is `rst_n`, asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- AR_VALID  in  1  read address valid
- AR_ADDR  in  17  read byte address
- AR_READY  out  1  read address ready
- R_VALID  out  1  read data valid
- R_DATA  out  32  read data
- R_RESP  out  2  read response
- R_READY  in  1  read data ready
- AW_VALID  in  1  write address valid
- AW_ADDR  in  17  write byte address
- AW_READY  out  1  write address ready
- W_VALID  in  1  write data valid
- W_DATA  in  32  write data
- W_READY  out  1  write data ready
- B_VALID  out  1  write response valid
- B_RESP  out  2  write response
- B_READY  in  1  write response ready

## Operation
- Exactly one transaction is in flight at a time; all outputs are registered.
- FSM states: S_IDLE, S_AR, S_RLAT, S_R, S_AW, S_WWAIT, S_W, S_WLAT, S_B.
- Arbitration in S_IDLE:
  - AR_VALID=1 → S_AR.
  - else AW_VALID=1 → S_AW.
  - Both high: read wins; AW waits.
- S_AR: AR_READY=1 for exactly one cycle, which is the handshake.
  - Latch AR_ADDR.
  - Load latency counter with RD_LAT−1, then go to S_RLAT.
- S_RLAT: decrement the counter. At 0, drive R_VALID=1, R_DATA, and R_RESP, then go to S_R.
- S_R: hold R_VALID/R_DATA/R_RESP stable until R_READY=1. On that cycle's edge, clear R_VALID and return to S_IDLE.
- S_AW: AW_READY=1 for one cycle; latch AW_ADDR, then go to S_WWAIT.
- S_WWAIT: wait for W_VALID=1, then go to S_W.
- S_W: W_READY=1 for one cycle.
  - Write W_DATA to the word on this edge if the address is legal.
  - Load the counter with WR_LAT−1, then go to S_WLAT.
- S_WLAT: count to 0, then drive B_VALID=1 with B_RESP and go to S_B.
- S_B: hold B_VALID until B_READY=1, then return to S_IDLE.
- Legal address rule: ADDR[16:10]==BASE_HI and ADDR[1:0]==0.
  - Illegal read: R_DATA=0, R_RESP=2'b10 (SLVERR).
  - Illegal write: no store update, B_RESP=2'b10.
  - Legal access: response is 2'b00 (OKAY).
- READY signals assert only in response to a sampled VALID; a READY is never high while S_IDLE.
- Write-then-read to the same address returns the new data.

## Timing
- Reset values: all outputs are 0 and the FSM is in S_IDLE. Store contents are not reset and persist across rst_n.
- Reset mid-transaction: return to S_IDLE immediately. A write that has not reached S_W leaves the store untouched.
- Read timeline, with t = first cycle AR_VALID is sampled high in S_IDLE:
  - AR_READY is high at t+1.
  - R_VALID rises at t+1+RD_LAT.
  - With the bridge's registered R_READY, the R handshake lands at t+2+RD_LAT.
- Write timeline:
  - AW_READY is high at t+1.
  - W_READY is high one cycle after W_VALID is sampled in S_WWAIT.
  - B_VALID rises WR_LAT cycles after the W handshake.
- Minimum back-to-back spacing: a new AR or AW is sampled no earlier than the cycle after the R or B handshake.

## Structure
- Shared package holds:
  - the AXI_RESP enum (OKAY=2'b00, SLVERR=2'b10);
  - the slave state enum;
  - the BASE_HI constant;
  - the address and data width localparams.
- One sub-module, `dram_word_array`: DEPTH × DATA_W storage with synchronous write and asynchronous read, and no reset.
- The latency counter is 4 bits wide.

## Test plan
- Write then read, RD_LAT=2, WR_LAT=1:
  - Stimulus: AW 0x10040 with W 0xDEADBEEF, then AR 0x10040.
  - Required: B_RESP=00; R_DATA=0xDEADBEEF with R_RESP=00; R_VALID rises exactly 3 cycles after AR_VALID is sampled.
- Illegal address:
  - Stimulus: AR 0x00040, then AW 0x10042.
  - Required: the read returns R_RESP=10 with R_DATA=0; the write returns B_RESP=10, and a later read of 0x10040 still returns the old data.
- Simultaneous request:
  - Stimulus: AR_VALID and AW_VALID rise on the same cycle.
  - Required: AR_READY pulses first; AW_READY pulses only after the R handshake.
- Backpressure:
  - Stimulus: hold R_READY and B_READY low for 5 cycles.
  - Required: R_VALID/R_DATA and B_VALID/B_RESP stay constant throughout, with exactly one handshake each.
- Reset mid-read:
  - Stimulus: assert rst_n low while in S_RLAT.
  - Required: all outputs are 0 next sample, and the next read of any prior-written word returns its stored value.
- Boundary words:
  - Stimulus: write then read 0x10000 and 0x103FC, each with 0xA5A5A5A5.
  - Required: both return 0xA5A5A5A5 with OKAY.

Source files
------------

// File: rtl/axi_lite_dram_slave_pkg.sv
// Shared types and constants for the AXI4-Lite word-store slave.
package axi_lite_dram_slave_pkg;

  localparam int unsigned AXI_ADDR_W   = 17;
  localparam int unsigned AXI_DATA_W   = 32;
  localparam int unsigned MEM_DEPTH    = 256;
  localparam int unsigned MEM_IDX_W    = 8;
  localparam int unsigned LAT_CNT_W    = 4;
  localparam logic [6:0]  DRAM_BASE_HI = 7'b1000000;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_AR,
    S_RLAT,
    S_R,
    S_AW,
    S_WWAIT,
    S_W,
    S_WLAT,
    S_B
  } slave_state_e;

endpackage

// File: rtl/dram_word_array.sv
// Word store: synchronous write, asynchronous read, contents survive reset.
module dram_word_array #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_lite_dram_slave.sv
// AXI4-Lite slave serving one outstanding read or write at a time from a
// word store, with fixed read and write response latencies.
module axi_lite_dram_slave
  import axi_lite_dram_slave_pkg::*;
#(
  parameter int unsigned ADDR_W  = AXI_ADDR_W,
  parameter int unsigned DATA_W  = AXI_DATA_W,
  parameter int unsigned DEPTH   = MEM_DEPTH,
  parameter logic [6:0]  BASE_HI = DRAM_BASE_HI,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned WR_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AR_VALID,
  input  logic [ADDR_W-1:0] AR_ADDR,
  output logic              AR_READY,
  output logic              R_VALID,
  output logic [DATA_W-1:0] R_DATA,
  output logic [1:0]        R_RESP,
  input  logic              R_READY,
  input  logic              AW_VALID,
  input  logic [ADDR_W-1:0] AW_ADDR,
  output logic              AW_READY,
  input  logic              W_VALID,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_READY,
  output logic              B_VALID,
  output logic [1:0]        B_RESP,
  input  logic              B_READY
);

  localparam logic [LAT_CNT_W-1:0] RD_CNT = LAT_CNT_W'(RD_LAT - 1);
  localparam logic [LAT_CNT_W-1:0] WR_CNT = LAT_CNT_W'(WR_LAT - 1);

  slave_state_e          state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d, b_resp_q, b_resp_d;
  logic                  ar_ready_q, aw_ready_q, w_ready_q, r_valid_q, b_valid_q;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_ok, wr_ok, mem_we;
  logic [DATA_W-1:0]     mem_rdata;

  // The read address is still on AR_ADDR during S_AR, so a 1-cycle read latency can use it.
  assign rd_addr = (state_q == S_AR) ? AR_ADDR : addr_q;
  assign rd_ok   = (rd_addr[ADDR_W-1 -: 7] == BASE_HI) && (rd_addr[1:0] == 2'b00);
  assign wr_ok   = (addr_q[ADDR_W-1 -: 7] == BASE_HI) && (addr_q[1:0] == 2'b00);

  dram_word_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (MEM_IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (addr_q[MEM_IDX_W+1:2]),
    .wdata_i (W_DATA),
    .raddr_i (rd_addr[MEM_IDX_W+1:2]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Latency states exit on the cycle the counter steps down to zero.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (AR_VALID)      state_d = S_AR;
        else if (AW_VALID) state_d = S_AW;
      end
      S_AR: begin
        if (RD_LAT == 1) state_d = S_R;
        else             state_d = S_RLAT;
      end
      S_RLAT:  if (cnt_q == LAT_CNT_W'(1)) state_d = S_R;
      S_R:     if (R_READY) state_d = S_IDLE;
      S_AW:    state_d = S_WWAIT;
      S_WWAIT: if (W_VALID) state_d = S_W;
      S_W: begin
        if (WR_LAT == 1) state_d = S_B;
        else             state_d = S_WLAT;
      end
      S_WLAT:  if (cnt_q == LAT_CNT_W'(1)) state_d = S_B;
      S_B:     if (B_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    b_resp_d = b_resp_q;
    mem_we   = 1'b0;
    unique case (state_q)
      S_AR: begin
        addr_d = AR_ADDR;
        cnt_d  = RD_CNT;
      end
      S_AW: addr_d = AW_ADDR;
      S_W: begin
        cnt_d  = WR_CNT;
        mem_we = wr_ok;
      end
      S_RLAT, S_WLAT: cnt_d = cnt_q - LAT_CNT_W'(1);
      default: ;
    endcase
    // Response payloads are captured once on entry and held while the master stalls.
    if (state_d == S_R && state_q != S_R) begin
      r_data_d = rd_ok ? mem_rdata : '0;
      r_resp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
    if (state_d == S_B && state_q != S_B) begin
      b_resp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      b_resp_q   <= RESP_OKAY;
      ar_ready_q <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      b_resp_q   <= b_resp_d;
      ar_ready_q <= (state_d == S_AR);
      aw_ready_q <= (state_d == S_AW);
      w_ready_q  <= (state_d == S_W);
      r_valid_q  <= (state_d == S_R);
      b_valid_q  <= (state_d == S_B);
    end
  end

  assign AR_READY = ar_ready_q;
  assign AW_READY = aw_ready_q;
  assign W_READY  = w_ready_q;
  assign R_VALID  = r_valid_q;
  assign R_DATA   = r_data_q;
  assign R_RESP   = r_resp_q;
  assign B_VALID  = b_valid_q;
  assign B_RESP   = b_resp_q;

endmodule

// File: tb/tb_axi_lite_dram_slave.sv
// Bench for axi_lite_dram_slave: directed cases plus randomized traffic,
// checked every cycle against a transaction-level memory model.
module tb_axi_lite_dram_slave;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WR_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        AR_VALID = 1'b0, R_READY = 1'b0, AW_VALID = 1'b0, W_VALID = 1'b0, B_READY = 1'b0;
  logic [16:0] AR_ADDR = '0, AW_ADDR = '0;
  logic [31:0] W_DATA = '0;
  logic        AR_READY, R_VALID, AW_READY, W_READY, B_VALID;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP, B_RESP;

  always #5 clk = ~clk;

  axi_lite_dram_slave #(
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .AR_VALID (AR_VALID),
    .AR_ADDR  (AR_ADDR),
    .AR_READY (AR_READY),
    .R_VALID  (R_VALID),
    .R_DATA   (R_DATA),
    .R_RESP   (R_RESP),
    .R_READY  (R_READY),
    .AW_VALID (AW_VALID),
    .AW_ADDR  (AW_ADDR),
    .AW_READY (AW_READY),
    .W_VALID  (W_VALID),
    .W_DATA   (W_DATA),
    .W_READY  (W_READY),
    .B_VALID  (B_VALID),
    .B_RESP   (B_RESP),
    .B_READY  (B_READY)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Expected per-cycle outputs, maintained by the transaction tasks.
  logic        exp_ar_ready = 1'b0, exp_aw_ready = 1'b0, exp_w_ready = 1'b0;
  logic        exp_r_valid = 1'b0, exp_b_valid = 1'b0, exp_rd_known = 1'b0;
  logic [31:0] exp_r_data = '0;
  logic [1:0]  exp_r_resp = '0, exp_b_resp = '0;

  logic [31:0] mmem [256];
  bit          mval [256];

  int          r_hs = 0, b_hs = 0, rv_rise_cyc = 0, ar_cyc = 0;
  logic        prev_rv = 1'b0;
  logic [31:0] last_r_data = '0;
  logic [1:0]  last_r_resp = '0, last_b_resp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [16:0] a);
    return (a[16:10] == 7'h40) && (a[1:0] == 2'b00);
  endfunction

  always @(negedge clk) begin
    chk("AR_READY", 32'(AR_READY), 32'(exp_ar_ready));
    chk("AW_READY", 32'(AW_READY), 32'(exp_aw_ready));
    chk("W_READY",  32'(W_READY),  32'(exp_w_ready));
    chk("R_VALID",  32'(R_VALID),  32'(exp_r_valid));
    chk("B_VALID",  32'(B_VALID),  32'(exp_b_valid));
    if (exp_r_valid) begin
      if (exp_rd_known) chk("R_DATA", R_DATA, exp_r_data);
      chk("R_RESP", 32'(R_RESP), 32'(exp_r_resp));
    end
    if (exp_b_valid) chk("B_RESP", 32'(B_RESP), 32'(exp_b_resp));
    if (R_VALID && R_READY) r_hs++;
    if (B_VALID && B_READY) b_hs++;
    if (R_VALID) begin
      last_r_data = R_DATA;
      last_r_resp = R_RESP;
    end
    if (B_VALID) last_b_resp = B_RESP;
    if (R_VALID && !prev_rv) rv_rise_cyc = cyc;
    prev_rv = R_VALID;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [16:0] addr, input int hold);
    bit ok;
    int idx;
    ok  = legal(addr);
    idx = int'(addr[9:2]);
    AR_VALID = 1'b1;
    AR_ADDR  = addr;
    ar_cyc   = cyc;
    tick();
    exp_ar_ready = 1'b1;
    tick();
    AR_VALID     = 1'b0;
    AR_ADDR      = 17'($urandom);
    exp_ar_ready = 1'b0;
    repeat (RD_LAT - 1) tick();
    exp_r_valid  = 1'b1;
    exp_r_data   = ok ? mmem[idx] : 32'h0;
    exp_r_resp   = ok ? 2'b00 : 2'b10;
    exp_rd_known = !ok || mval[idx];
    repeat (hold) tick();
    R_READY = 1'b1;
    tick();
    R_READY     = 1'b0;
    exp_r_valid = 1'b0;
  endtask

  task automatic do_write(input logic [16:0] addr, input logic [31:0] data,
                          input int wdelay, input int hold);
    bit ok;
    int idx;
    ok  = legal(addr);
    idx = int'(addr[9:2]);
    AW_VALID = 1'b1;
    AW_ADDR  = addr;
    tick();
    exp_aw_ready = 1'b1;
    tick();
    AW_VALID     = 1'b0;
    AW_ADDR      = 17'($urandom);
    exp_aw_ready = 1'b0;
    repeat (wdelay) tick();
    W_VALID = 1'b1;
    W_DATA  = data;
    tick();
    exp_w_ready = 1'b1;
    tick();
    W_VALID     = 1'b0;
    W_DATA      = $urandom;
    exp_w_ready = 1'b0;
    if (ok) begin
      mmem[idx] = data;
      mval[idx] = 1'b1;
    end
    repeat (WR_LAT - 1) tick();
    exp_b_valid = 1'b1;
    exp_b_resp  = ok ? 2'b00 : 2'b10;
    repeat (hold) tick();
    B_READY = 1'b1;
    tick();
    B_READY     = 1'b0;
    exp_b_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    logic [16:0] a;
    int k;
    for (int i = 0; i < 256; i++) begin
      mmem[i] = '0;
      mval[i] = 1'b0;
    end

    // Reset state
    @(negedge clk);
    chk("rst_R_DATA", R_DATA, 32'h0);
    chk("rst_R_RESP", 32'(R_RESP), 32'h0);
    chk("rst_B_RESP", 32'(B_RESP), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Write then read
    do_write(17'h10040, 32'hDEADBEEF, 0, 1);
    chk("wr_bresp_okay", 32'(last_b_resp), 32'h0);
    do_read(17'h10040, 1);
    chk("rd_data", last_r_data, 32'hDEADBEEF);
    chk("rd_resp_okay", 32'(last_r_resp), 32'h0);
    chk("rd_rvalid_delay", 32'(rv_rise_cyc - ar_cyc), 32'd3);

    // Illegal addresses
    do_read(17'h00040, 0);
    chk("ill_rd_resp", 32'(last_r_resp), 32'h2);
    chk("ill_rd_data", last_r_data, 32'h0);
    do_write(17'h10042, 32'h12345678, 1, 0);
    chk("ill_wr_resp", 32'(last_b_resp), 32'h2);
    do_read(17'h10040, 1);
    chk("ill_wr_nochg", last_r_data, 32'hDEADBEEF);

    // Simultaneous AR and AW: read first, write after the R handshake
    AW_VALID = 1'b1;
    AW_ADDR  = 17'h10080;
    do_read(17'h10040, 1);
    do_write(17'h10080, 32'hCAFEF00D, 0, 1);
    do_read(17'h10080, 1);
    chk("simul_wr_data", last_r_data, 32'hCAFEF00D);

    // Backpressure
    hs0 = r_hs;
    do_read(17'h10040, 5);
    chk("bp_r_handshakes", 32'(r_hs - hs0), 32'd1);
    hs0 = b_hs;
    do_write(17'h10044, 32'h0F0F0F0F, 2, 5);
    chk("bp_b_handshakes", 32'(b_hs - hs0), 32'd1);

    // Boundary words
    do_write(17'h10000, 32'hA5A5A5A5, 0, 1);
    do_write(17'h103FC, 32'hA5A5A5A5, 0, 1);
    do_read(17'h10000, 1);
    chk("bnd_lo_data", last_r_data, 32'hA5A5A5A5);
    chk("bnd_lo_resp", 32'(last_r_resp), 32'h0);
    do_read(17'h103FC, 1);
    chk("bnd_hi_data", last_r_data, 32'hA5A5A5A5);
    chk("bnd_hi_resp", 32'(last_r_resp), 32'h0);

    // Reset while the read latency is counting
    AR_VALID = 1'b1;
    AR_ADDR  = 17'h10044;
    tick();
    exp_ar_ready = 1'b1;
    tick();
    AR_VALID     = 1'b0;
    exp_ar_ready = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    chk("mid_rst_R_DATA", R_DATA, 32'h0);
    chk("mid_rst_R_RESP", 32'(R_RESP), 32'h0);
    chk("mid_rst_B_RESP", 32'(B_RESP), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    do_read(17'h10040, 1);
    chk("rst_persist", last_r_data, 32'hDEADBEEF);

    // Reset while waiting for write data leaves the store alone
    AW_VALID = 1'b1;
    AW_ADDR  = 17'h10040;
    tick();
    exp_aw_ready = 1'b1;
    tick();
    AW_VALID     = 1'b0;
    exp_aw_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_read(17'h10040, 1);
    chk("rst_wr_abort", last_r_data, 32'hDEADBEEF);

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      k = int'($urandom_range(0, 9));
      a = {7'h40, 8'($urandom_range(0, 31)), 2'b00};
      if (k == 0)      a = 17'($urandom);
      else if (k == 1) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        do_read(a, int'($urandom_range(0, 3)));
    end

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
